// File: rtl/boot_loader.sv
// boot_loader -- UART image loader that fills program RAM before releasing the CPU.
//
// Byte stream: LEN_LO, LEN_HI (word count N), N x {lo, hi}, then an optional
// checksum byte. While loading, the loader owns RAM port A and holds the CPU in
// reset. Once the image is in, RAM port A is handed to the CPU data port with
// zero latency.
//
// Build option: define BOOT_LOADER_CKSUM_EN to require a trailing 8-bit checksum
// byte (mod-256 sum of all data bytes). Without it, the last word write boots.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rx_rdata, rx_d_valid     UART receive FIFO head byte / non-empty flag
//   rx_rd                    one-cycle FIFO pop strobe
//   cpu_mem_addr/dout/wr     CPU data-port write request
//   ram_addr/wdata/wr        RAM port A (loader, or CPU once running)
//   cpu_hold                 holds the CPU in reset
//   boot_done                image loaded, CPU released
//   boot_err                 load failed, sticky until rst
module boot_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_rdata,
  input  logic                  rx_d_valid,
  output logic                  rx_rd,
  input  logic [ADDR_WIDTH-1:0] cpu_mem_addr,
  input  logic [DATA_WIDTH-1:0] cpu_dout,
  input  logic                  cpu_mem_wr,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_wr,
  output logic                  cpu_hold,
  output logic                  boot_done,
  output logic                  boot_err
);

  localparam logic [2:0] S_LEN_LO = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_DAT_LO = 3'd2;
  localparam logic [2:0] S_DAT_HI = 3'd3;
`ifdef BOOT_LOADER_CKSUM_EN
  localparam logic [2:0] S_CKSUM  = 3'd4;
  localparam logic [2:0] S_AFTER  = S_CKSUM;   // state following the last word
`else
  localparam logic [2:0] S_AFTER  = 3'd5;
`endif
  localparam logic [2:0] S_RUN    = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // Largest legal word count; one bit wider than the 16-bit length field.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  logic [2:0]            state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [7:0]            lo_q, lo_d;
  logic [15:0]           left_q, left_d;     // words still to be written
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  rx_rd_q, rx_rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
`ifdef BOOT_LOADER_CKSUM_EN
  logic [7:0]            sum_q, sum_d;
`endif

  logic        recv, timed, accept;
  logic [15:0] n_words;

  assign recv    = (state_q != S_RUN) && (state_q != S_ERR);
  assign timed   = recv && (state_q != S_LEN_LO);
  // rx_rd_q high means the head is being popped this cycle; never pop twice in a row.
  assign accept  = recv && rx_d_valid && !rx_rd_q;
  assign n_words = {rx_rdata, len_lo_q};

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    lo_d     = lo_q;
    left_d   = left_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rx_rd_d  = accept;
    wr_d     = 1'b0;
    tmo_d    = (timed && !accept) ? tmo_q + TW'(1) : '0;
    // Status lags the state by one cycle so the final loader write completes
    // before the port is handed to the CPU.
    hold_d   = (state_q != S_RUN);
    done_d   = (state_q == S_RUN);
    err_d    = (state_q == S_ERR);
`ifdef BOOT_LOADER_CKSUM_EN
    sum_d    = sum_q;
`endif
    if (accept) begin
      case (state_q)
        S_LEN_LO: begin
          len_lo_d = rx_rdata;
          state_d  = S_LEN_HI;
        end
        S_LEN_HI: begin
          left_d = n_words;
          if ({1'b0, n_words} > MAX_WORDS) state_d = S_ERR;
          else if (n_words == 16'd0)       state_d = S_AFTER;
          else                             state_d = S_DAT_LO;
        end
        S_DAT_LO: begin
          lo_d    = rx_rdata;
`ifdef BOOT_LOADER_CKSUM_EN
          sum_d   = sum_q + rx_rdata;
`endif
          state_d = S_DAT_HI;
        end
        S_DAT_HI: begin
          wr_d    = 1'b1;
          addr_d  = ptr_q;
          wdata_d = DATA_WIDTH'({rx_rdata, lo_q});
          ptr_d   = ptr_q + ADDR_WIDTH'(1);
          left_d  = left_q - 16'd1;
`ifdef BOOT_LOADER_CKSUM_EN
          sum_d   = sum_q + rx_rdata;
`endif
          state_d = (left_q == 16'd1) ? S_AFTER : S_DAT_LO;
        end
`ifdef BOOT_LOADER_CKSUM_EN
        S_CKSUM: state_d = (rx_rdata == sum_q) ? S_RUN : S_ERR;
`endif
        default: ;
      endcase
    end else if (timed && (tmo_q == TW'(TIMEOUT - 1))) begin
      state_d = S_ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LEN_LO;
      len_lo_q <= '0;
      lo_q     <= '0;
      left_q   <= '0;
      ptr_q    <= '0;
      tmo_q    <= '0;
      rx_rd_q  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef BOOT_LOADER_CKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      lo_q     <= lo_d;
      left_q   <= left_d;
      ptr_q    <= ptr_d;
      tmo_q    <= tmo_d;
      rx_rd_q  <= rx_rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef BOOT_LOADER_CKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign rx_rd     = rx_rd_q;
  assign cpu_hold  = hold_q;
  assign boot_done = done_q;
  assign boot_err  = err_q;
  // CPU owns RAM port A once running; the only unregistered path in the block.
  assign ram_wr    = done_q ? cpu_mem_wr   : wr_q;
  assign ram_addr  = done_q ? cpu_mem_addr : addr_q;
  assign ram_wdata = done_q ? cpu_dout     : wdata_q;

endmodule
